// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : PC width, reset PC and in-flight entry shared across fetch/BHT/EX
// Rev 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_W = 11;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred_next;
    } inflight_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_if : fetch PC, BHT lookup, resolve and BHT update signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface pc_fetch_if;
    import fetch_pkg::*;

    logic            stall;
    logic [PC_W-1:0] pc_fetch;
    logic            fetch_valid;
    logic            bht_hit;
    logic [PC_W-1:0] bht_target;
    logic            resolve_valid;
    logic            resolve_taken;
    logic [PC_W-1:0] resolve_target;
    logic            flush;
    logic            upd_valid;
    logic [PC_W-1:0] pc_fetch_update;
    logic [PC_W-1:0] pc_target_update;

    modport master (
        input  stall, bht_hit, bht_target,
        input  resolve_valid, resolve_taken, resolve_target,
        output pc_fetch, fetch_valid, flush,
        output upd_valid, pc_fetch_update, pc_target_update
    );

    modport slave (
        output stall, bht_hit, bht_target,
        output resolve_valid, resolve_taken, resolve_target,
        input  pc_fetch, fetch_valid, flush,
        input  upd_valid, pc_fetch_update, pc_target_update
    );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit_inflight_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inflight_fifo : synchronous FIFO with clear; clear wins over a same-cycle push
// Rev 1.0
// ---------------------------------------------------------------------------
module inflight_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_ONE   = (c_PTR_W+1)'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_unit : fetch PC generator with prediction, in-flight tracking,
//                 mispredict redirect/flush and BHT/BTB update generation
// Rev 1.0
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input wire logic   clk,
    input wire logic   rst_n,
    pc_fetch_if.master bus
);

    logic [PC_W-1:0] r_pc;
    logic            r_flush;
    logic            r_upd_valid;
    logic [PC_W-1:0] r_upd_pc;
    logic [PC_W-1:0] r_upd_tgt;

    logic [PC_W-1:0] w_pred_next;
    logic            w_fetch_valid;
    logic            w_full;
    logic            w_empty;
    inflight_t       w_push_data;
    inflight_t       w_head;
    logic            w_resolve;
    logic [PC_W-1:0] w_head_inc;
    logic [PC_W-1:0] w_act;
    logic            w_mispredict;
    logic            w_upd;

    assign w_pred_next   = bus.bht_hit ? bus.bht_target : r_pc + 1'b1;
    assign w_fetch_valid = !bus.stall && !w_full && !r_flush;
    assign w_push_data   = '{pc: r_pc, pred_next: w_pred_next};

    assign w_resolve    = bus.resolve_valid && !w_empty;
    assign w_head_inc   = w_head.pc + 1'b1;
    assign w_act        = bus.resolve_taken ? bus.resolve_target : w_head_inc;
    assign w_mispredict = w_resolve && (w_act != w_head.pred_next);
    // A correct taken prediction needs no write; a taken branch predicted
    // fall-through (BHT miss) is written even if its target is pc+1.
    assign w_upd        = w_resolve && bus.resolve_taken &&
                          (w_mispredict || (w_head.pred_next == w_head_inc));

    inflight_fifo #(
        .WIDTH ($bits(inflight_t)),
        .DEPTH (DEPTH)
    ) u_inflight_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_mispredict),
        .i_push  (w_fetch_valid),
        .i_data  (w_push_data),
        .i_pop   (w_resolve),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_flush     <= 1'b0;
            r_upd_valid <= 1'b0;
            r_upd_pc    <= '0;
            r_upd_tgt   <= '0;
        end else begin
            if (w_mispredict)       r_pc <= w_act;
            else if (w_fetch_valid) r_pc <= w_pred_next;
            r_flush     <= w_mispredict;
            r_upd_valid <= w_upd;
            if (w_upd) begin
                r_upd_pc  <= w_head.pc;
                r_upd_tgt <= bus.resolve_target;
            end
        end
    end

    assign bus.pc_fetch         = r_pc;
    assign bus.fetch_valid      = w_fetch_valid;
    assign bus.flush            = r_flush;
    assign bus.upd_valid        = r_upd_valid;
    assign bus.pc_fetch_update  = r_upd_pc;
    assign bus.pc_target_update = r_upd_tgt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit : vector table, reset corner sequence and random run vs model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;
    import fetch_pkg::*;

    localparam int              DEPTH  = 4;
    localparam logic [PC_W-1:0] RST_PC = 11'h010;

    typedef logic [PC_W-1:0] pc_t;

    typedef struct {
        logic st; logic hit; pc_t tgt; logic rv; logic tk; pc_t rt;
        pc_t e_pc; logic e_fv; logic e_fl; logic e_up; pc_t e_upc; pc_t e_utgt;
    } vec_t;

    typedef struct { pc_t pc; pc_t pred; } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_if u_if();

    pc_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.master)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    vec_t tbl[$];

    // Reference model state: a queue of issued {pc, predicted successor}.
    ent_t m_q[$];
    pc_t  m_pc, m_upc, m_utgt;
    logic m_fl, m_up;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic hit, input pc_t tgt,
                         input logic rv, input logic tk, input pc_t rt);
        u_if.stall          = st;
        u_if.bht_hit        = hit;
        u_if.bht_target     = tgt;
        u_if.resolve_valid  = rv;
        u_if.resolve_taken  = tk;
        u_if.resolve_target = rt;
    endtask

    task automatic expect_out(input string tag, input pc_t pc, input logic fv, input logic fl,
                              input logic up, input pc_t upc, input pc_t utgt);
        chk({tag, ".pc_fetch"},         32'(u_if.pc_fetch),         32'(pc));
        chk({tag, ".fetch_valid"},      32'(u_if.fetch_valid),      32'(fv));
        chk({tag, ".flush"},            32'(u_if.flush),            32'(fl));
        chk({tag, ".upd_valid"},        32'(u_if.upd_valid),        32'(up));
        chk({tag, ".pc_fetch_update"},  32'(u_if.pc_fetch_update),  32'(upc));
        chk({tag, ".pc_target_update"}, 32'(u_if.pc_target_update), 32'(utgt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic hit, input pc_t tgt, input logic rv,
                       input logic tk, input pc_t rt, input pc_t pc, input logic fv,
                       input logic fl, input logic up, input pc_t upc, input pc_t utgt);
        vec_t v;
        v = '{st, hit, tgt, rv, tk, rt, pc, fv, fl, up, upc, utgt};
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc   = RST_PC;
        m_fl   = 1'b0;
        m_up   = 1'b0;
        m_upc  = '0;
        m_utgt = '0;
    endtask

    function automatic logic model_fv(input logic st);
        return !st && (m_q.size() < DEPTH) && !m_fl;
    endfunction

    task automatic model_step(input logic st, input logic hit, input pc_t tgt,
                              input logic rv, input logic tk, input pc_t rt);
        logic fv, mis, up;
        pc_t  pred, act, nxt;
        ent_t h, e;
        fv   = model_fv(st);
        pred = hit ? tgt : pc_t'(m_pc + 1);
        mis  = 1'b0;
        up   = 1'b0;
        act  = '0;
        if (rv && m_q.size() > 0) begin
            h   = m_q.pop_front();
            nxt = pc_t'(h.pc + 1);
            act = tk ? rt : nxt;
            mis = (act != h.pred);
            up  = tk && (mis || h.pred == nxt);
            if (up) begin
                m_upc  = h.pc;
                m_utgt = rt;
            end
        end
        if (mis) begin
            m_q.delete();
            m_pc = act;
        end else if (fv) begin
            e = '{m_pc, pred};
            m_q.push_back(e);
            m_pc = pred;
        end
        m_fl = mis;
        m_up = up;
    endtask

    initial begin
        logic st, hit, rv, tk;
        pc_t  tgt, rt;

        //   st hit tgt     rv tk rt      | pc      fv fl up upc     utgt
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h010, 1, 0, 0, 11'h000, 11'h000);
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h011, 1, 0, 0, 11'h000, 11'h000);
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h012, 1, 0, 0, 11'h000, 11'h000);
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h013, 1, 0, 0, 11'h000, 11'h000);
        add(0, 0, 11'h000, 1, 0, 11'h000, 11'h014, 0, 0, 0, 11'h000, 11'h000);
        add(0, 1, 11'h020, 1, 0, 11'h000, 11'h014, 1, 0, 0, 11'h000, 11'h000);
        add(0, 1, 11'h100, 1, 0, 11'h000, 11'h020, 1, 0, 0, 11'h000, 11'h000);
        add(1, 0, 11'h000, 1, 0, 11'h000, 11'h100, 0, 0, 0, 11'h000, 11'h000);
        add(1, 0, 11'h000, 1, 1, 11'h020, 11'h100, 0, 0, 0, 11'h000, 11'h000);
        add(1, 0, 11'h000, 1, 1, 11'h100, 11'h100, 0, 0, 0, 11'h000, 11'h000);
        add(0, 0, 11'h000, 1, 0, 11'h000, 11'h100, 1, 0, 0, 11'h000, 11'h000);
        add(0, 0, 11'h000, 1, 1, 11'h030, 11'h101, 1, 0, 0, 11'h000, 11'h000);
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h030, 0, 1, 1, 11'h100, 11'h030);
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h030, 1, 0, 0, 11'h100, 11'h030);
        add(0, 0, 11'h000, 1, 1, 11'h200, 11'h031, 1, 0, 0, 11'h100, 11'h030);
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h200, 0, 1, 1, 11'h030, 11'h200);
        add(0, 1, 11'h7FF, 0, 0, 11'h000, 11'h200, 1, 0, 0, 11'h030, 11'h200);
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h7FF, 1, 0, 0, 11'h030, 11'h200);
        add(0, 0, 11'h000, 1, 0, 11'h000, 11'h000, 1, 0, 0, 11'h030, 11'h200);
        add(0, 0, 11'h000, 1, 1, 11'h555, 11'h201, 0, 1, 0, 11'h030, 11'h200);
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h201, 1, 0, 0, 11'h030, 11'h200);
        add(0, 1, 11'h020, 0, 0, 11'h000, 11'h202, 1, 0, 0, 11'h030, 11'h200);
        add(0, 1, 11'h100, 0, 0, 11'h000, 11'h020, 1, 0, 0, 11'h030, 11'h200);
        add(0, 0, 11'h000, 1, 0, 11'h000, 11'h100, 1, 0, 0, 11'h030, 11'h200);
        add(0, 0, 11'h000, 1, 1, 11'h020, 11'h101, 1, 0, 0, 11'h030, 11'h200);
        add(0, 0, 11'h000, 1, 0, 11'h000, 11'h102, 1, 0, 0, 11'h030, 11'h200);
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h021, 0, 1, 0, 11'h030, 11'h200);
        add(0, 0, 11'h000, 0, 0, 11'h000, 11'h021, 1, 0, 0, 11'h030, 11'h200);

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].hit, tbl[i].tgt, tbl[i].rv, tbl[i].tk, tbl[i].rt);
            #1;
            expect_out($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_fv, tbl[i].e_fl,
                       tbl[i].e_up, tbl[i].e_upc, tbl[i].e_utgt);
            tick();
        end

        // Fill to three in-flight entries, then reset asynchronously mid-cycle.
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #1;
        chk("fill0.pc_fetch", 32'(u_if.pc_fetch), 32'h022);
        tick();
        chk("fill1.pc_fetch", 32'(u_if.pc_fetch), 32'h023);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", RST_PC, 1'b0, 1'b0, 1'b0, 11'h000, 11'h000);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 11'h3AA);
        #1;
        expect_out("rel0", RST_PC, 1'b1, 1'b0, 1'b0, 11'h000, 11'h000);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #1;
        expect_out("rel1", 11'h011, 1'b1, 1'b0, 1'b0, 11'h000, 11'h000);
        tick();

        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            st  = ($urandom_range(3, 0) == 0);
            hit = ($urandom_range(4, 0) < 2);
            tgt = pc_t'($urandom_range(2047, 0));
            rv  = ($urandom_range(1, 0) == 1);
            tk  = ($urandom_range(1, 0) == 1);
            rt  = pc_t'($urandom_range(2047, 0));
            if (rv && m_q.size() > 0 && $urandom_range(2, 0) != 0) begin
                rt = m_q[0].pred;
                tk = (m_q[0].pred != pc_t'(m_q[0].pc + 1)) ? 1'b1 : 1'($urandom_range(1, 0));
            end
            drive(st, hit, tgt, rv, tk, rt);
            #1;
            expect_out($sformatf("rnd%0d", c), m_pc, model_fv(st), m_fl, m_up, m_upc, m_utgt);
            model_step(st, hit, tgt, rv, tk, rt);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
